// File: rtl/stream_out_multi.sv
// Multi-lane bus-to-stream serializer with valid/ready backpressure.
// Define STREAM_OUT_SNAPSHOT_EN to capture the bus at start instead of reading it live.
module stream_out_multi #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    TOTAL_ELEM = 16,
  parameter int                    LANES      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  localparam int                   CNT_WIDTH  = $clog2(TOTAL_ELEM+1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [TOTAL_ELEM*DATA_WIDTH-1:0] bus_data_i,
  input  logic [CNT_WIDTH-1:0]             num_elem_i,
  input  logic                             start_i,
  input  logic                             clr_i,
  output logic [LANES*DATA_WIDTH-1:0]      stream_data_o,
  output logic [LANES-1:0]                 stream_lane_valid_o,
  output logic                             stream_valid_o,
  input  logic                             stream_ready_i,
  output logic                             stream_last_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int IW = CNT_WIDTH + 1;
  localparam logic [IW-1:0] TE = IW'(TOTAL_ELEM);
  localparam logic [IW-1:0] LN = IW'(LANES);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          state;
  logic [IW-1:0]                   len;
  logic [IW-1:0]                   base;
  logic [IW-1:0]                   len_new;
  logic [IW-1:0]                   ld_base;
  logic [IW-1:0]                   ld_len;
  logic [IW-1:0]                   idx;
  logic [TOTAL_ELEM*DATA_WIDTH-1:0] ld_src;
  logic [LANES*DATA_WIDTH-1:0]     ld_data;
  logic [LANES-1:0]                ld_mask;
  logic                            ld_last;

`ifdef STREAM_OUT_SNAPSHOT_EN
  logic [TOTAL_ELEM*DATA_WIDTH-1:0] snap;
`endif

  always_comb begin
    len_new = IW'(num_elem_i);
    if (num_elem_i == '0 || IW'(num_elem_i) > TE)
      len_new = TE;
  end

  // One loader serves both the first beat (from IDLE) and every following beat.
  always_comb begin
    ld_base = '0;
    ld_len  = len_new;
    ld_src  = bus_data_i;
    if (state == STREAM) begin
      ld_base = base + LN;
      ld_len  = len;
`ifdef STREAM_OUT_SNAPSHOT_EN
      ld_src  = snap;
`endif
    end
    ld_data = {LANES{RESET_VAL}};
    ld_mask = '0;
    idx     = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = ld_base + IW'(k);
      if (idx < ld_len) begin
        ld_mask[k] = 1'b1;
        for (int j = 0; j < TOTAL_ELEM; j++)
          if (idx == IW'(j))
            ld_data[k*DATA_WIDTH +: DATA_WIDTH] =
              ld_src[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ld_last = (ld_base + LN >= ld_len);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= IDLE;
      len                 <= '0;
      base                <= '0;
      stream_data_o       <= {LANES{RESET_VAL}};
      stream_lane_valid_o <= '0;
      stream_valid_o      <= 1'b0;
      stream_last_o       <= 1'b0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
`ifdef STREAM_OUT_SNAPSHOT_EN
      snap                <= '0;
`endif
    end else if (clr_i) begin
      state               <= IDLE;
      base                <= '0;
      stream_data_o       <= {LANES{RESET_VAL}};
      stream_lane_valid_o <= '0;
      stream_valid_o      <= 1'b0;
      stream_last_o       <= 1'b0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state               <= STREAM;
            len                 <= len_new;
            base                <= '0;
            stream_data_o       <= ld_data;
            stream_lane_valid_o <= ld_mask;
            stream_valid_o      <= 1'b1;
            stream_last_o       <= ld_last;
            busy_o              <= 1'b1;
`ifdef STREAM_OUT_SNAPSHOT_EN
            snap                <= bus_data_i;
`endif
          end
        end
        STREAM: begin
          if (stream_valid_o && stream_ready_i) begin
            if (stream_last_o) begin
              state               <= IDLE;
              stream_data_o       <= {LANES{RESET_VAL}};
              stream_lane_valid_o <= '0;
              stream_valid_o      <= 1'b0;
              stream_last_o       <= 1'b0;
              busy_o              <= 1'b0;
              done_o              <= 1'b1;
            end else begin
              base                <= ld_base;
              stream_data_o       <= ld_data;
              stream_lane_valid_o <= ld_mask;
              stream_last_o       <= ld_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_out_multi.sv
// Self-checking bench for stream_out_multi: directed scenarios plus
// randomized traffic against an element-position reference model.
module tb_stream_out_multi;

  localparam int DW = 16;
  localparam int TE = 16;
  localparam int LN = 2;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [TE*DW-1:0] bus_data;
  logic [CW-1:0]    num_elem;
  logic             start;
  logic             clr;
  logic             ready;
  logic [LN*DW-1:0] stream_data;
  logic [LN-1:0]    lane_valid;
  logic             stream_valid;
  logic             stream_last;
  logic             busy;
  logic             done;

  stream_out_multi dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .bus_data_i          (bus_data),
    .num_elem_i          (num_elem),
    .start_i             (start),
    .clr_i               (clr),
    .stream_data_o       (stream_data),
    .stream_lane_valid_o (lane_valid),
    .stream_valid_o      (stream_valid),
    .stream_ready_i      (ready),
    .stream_last_o       (stream_last),
    .busy_o              (busy),
    .done_o              (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: active transfer, next element position, length, source values
  bit            m_act  = 0;
  bit            m_done = 0;
  int            m_pos  = 0;
  int            m_len  = 0;
  logic [DW-1:0] m_src [TE];
  logic [TE*DW-1:0] bus_nx;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_src();
    for (int j = 0; j < TE; j++) m_src[j] = bus_data[j*DW +: DW];
  endtask

  task automatic compare();
    logic [LN*DW-1:0] ed;
    logic [LN-1:0]    em;
    ed = '0;
    em = '0;
    if (m_act)
      for (int k = 0; k < LN; k++)
        if (m_pos + k < m_len) begin
          em[k] = 1'b1;
          ed[k*DW +: DW] = m_src[m_pos + k];
        end
    check("valid", 64'(stream_valid), 64'(m_act));
    check("busy", 64'(busy), 64'(m_act));
    check("done", 64'(done), 64'(m_done));
    check("data", 64'(stream_data), 64'(ed));
    check("lane_valid", 64'(lane_valid), 64'(em));
    check("last", 64'(stream_last), 64'(m_act && (m_pos + LN >= m_len)));
  endtask

  // One clock: check outputs, drive inputs, predict the next cycle
  task automatic cyc(input logic s, input logic c, input logic r, input int n);
    @(negedge clk);
    compare();
    bus_data = bus_nx;
    start    = s;
    clr      = c;
    ready    = r;
    num_elem = CW'(n);
    if (c) begin
      m_act  = 0;
      m_done = 0;
    end else if (m_act) begin
      m_done = 0;
      if (r) begin
        if (m_pos + LN >= m_len) begin
          m_act  = 0;
          m_done = 1;
        end else begin
          m_pos += LN;
`ifndef STREAM_OUT_SNAPSHOT_EN
          load_src();
`endif
        end
      end
    end else begin
      m_done = 0;
      if (s) begin
        m_act = 1;
        m_pos = 0;
        m_len = (n == 0 || n > TE) ? TE : n;
        load_src();
      end
    end
  endtask

  task automatic rand_bus();
    for (int j = 0; j < TE; j++) bus_nx[j*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    num_elem = '0;
    for (int j = 0; j < TE; j++) bus_nx[j*DW +: DW] = DW'(j + 1);
    bus_data = bus_nx;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // full length, continuous ready
    cyc(1, 0, 1, 0);
    repeat (10) cyc(0, 0, 1, 0);
    // partial last beat
    cyc(1, 0, 1, 5);
    repeat (5) cyc(0, 0, 1, 0);
    // backpressure on beat 2
    cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 0, 1, 0);
    // clear during beat 3, then restart
    cyc(1, 0, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    repeat (2) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    repeat (10) cyc(0, 0, 1, 0);
    // start while busy, on last handshake, and on the done cycle
    cyc(1, 0, 1, 4);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 6);
    repeat (5) cyc(0, 0, 1, 0);
    // clear and start together
    cyc(1, 1, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);
    // bus changes after start
    cyc(1, 0, 1, 0);
    rand_bus();
    repeat (3) cyc(0, 0, 1, 0);
    rand_bus();
    repeat (8) cyc(0, 0, 1, 0);
    // async reset mid-transfer
    cyc(1, 0, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 64'(stream_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", 64'(stream_data), 64'd0);
    check("rst_mask", 64'(lane_valid), 64'd0);
    check("rst_last", 64'(stream_last), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_act  = 0;
    m_done = 0;
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!m_act && ($urandom % 2) == 0) rand_bus();
      cyc(($urandom % 4) == 0, ($urandom % 40) == 0,
          ($urandom % 4) != 0, int'($urandom % 32));
    end
    repeat (3) cyc(0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
